// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants, widths and FSM encoding for the video DDR write arbiter
package video_pkg;

  localparam int CH_NUM          = 4;
  localparam int DQ_WIDTH        = 32;
  localparam int BEAT_W          = DQ_WIDTH * 8;
  localparam int RD_ADDR_LEN     = 5;
  localparam int BEAT_IDX_W      = RD_ADDR_LEN - 1;
  localparam int BURST_LEN       = 1 << BEAT_IDX_W;
  localparam int CTRL_ADDR_WIDTH = 28;
  localparam int CH_ID_W         = 4;
  localparam int CUR_W           = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROBE    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_CMD      = 3'd3,
    ST_PREFETCH = 3'd4,
    ST_DATA     = 3'd5,
    ST_DONE     = 3'd6
  } arb_state_e;

  function automatic int slot_bits(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/video_wr_arbiter_rr_pointer.sv
// rtl/video_wr_arbiter_rr_pointer.sv - round-robin channel pointer (current grant and next slot)
module rr_pointer
  import video_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [CUR_W-1:0] o_cur
);

  logic [CUR_W-1:0] r_cur;
  logic [CUR_W-1:0] r_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cur  <= '0;
      r_next <= '0;
    end else begin
      if (i_load) begin
        r_cur <= r_next;
      end
      if (i_advance) begin
        r_next <= (r_cur == CUR_W'(CH_NUM - 1)) ? '0 : r_cur + CUR_W'(1);
      end
    end
  end

  assign o_cur = r_cur;

endmodule

// File: rtl/video_wr_arbiter.sv
// rtl/video_wr_arbiter.sv - round-robin burst scheduler from channel sampler RAMs to one DDR write port
module video_wr_arbiter
  import video_pkg::*;
#(
  parameter int                         FRAME_BEATS    = 3600,
  parameter logic [CTRL_ADDR_WIDTH-1:0] CH_BASE_STRIDE = 28'h0100000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [CH_NUM-1:0]          ch_rd_valid,
  input  logic [CH_NUM-1:0]          ch_ready,
  output logic [RD_ADDR_LEN-1:0]     ch_rd_addr,
  input  logic [CH_NUM*BEAT_W-1:0]   ch_rd_data,
  output logic                       wr_cmd_valid,
  input  logic                       wr_cmd_ready,
  output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [CH_ID_W-1:0]         wr_cmd_id,
  output logic [BEAT_W-1:0]          wr_data,
  output logic                       wr_data_valid,
  input  logic                       wr_data_ready,
  output logic                       wr_data_last,
  output logic [CH_NUM-1:0]          frame_done
);

  localparam int SLOTS = FRAME_BEATS / BURST_LEN;
  localparam int OFS_W = slot_bits(SLOTS);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [CUR_W-1:0]      w_cur;
  logic                  w_load;
  logic                  w_advance;
  logic                  r_probe_cnt;
  logic [CH_NUM-1:0]     r_half;
  logic                  r_rd_half;
  logic [BEAT_IDX_W-1:0] r_beat;
  logic [BEAT_IDX_W-1:0] w_beat_nxt;
  logic [BEAT_IDX_W-1:0] w_beat_sel;
  logic [OFS_W-1:0]      r_offset [CH_NUM];
  logic                  w_offset_wrap;
  logic                  w_last_beat;
  logic [CTRL_ADDR_WIDTH-1:0] w_cmd_addr;
  logic [BEAT_W-1:0]     w_ch_data [CH_NUM];

  rr_pointer u_rr_pointer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_cur     (w_cur)
  );

  for (genvar g = 0; g < CH_NUM; g++) begin : g_slice
    assign w_ch_data[g] = ch_rd_data[g*BEAT_W +: BEAT_W];
  end

  assign w_beat_nxt    = r_beat + BEAT_IDX_W'(1);
  assign w_beat_sel    = wr_data_ready ? w_beat_nxt : r_beat;
  assign w_last_beat   = (r_beat == BEAT_IDX_W'(BURST_LEN - 1));
  assign w_offset_wrap = (r_offset[w_cur] == OFS_W'(SLOTS - 1));
  assign w_cmd_addr    = (CH_BASE_STRIDE * CTRL_ADDR_WIDTH'(w_cur))
                       + (CTRL_ADDR_WIDTH'(r_offset[w_cur]) << BEAT_IDX_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_probe_cnt <= 1'b0;
      r_half      <= '0;
      r_rd_half   <= 1'b0;
      r_beat      <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_offset[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_PROBE) begin
        r_probe_cnt <= ~r_probe_cnt;
      end
      // Half flips on every probe so it tracks the sampler's own probe counter.
      if (r_state == ST_CHECK) begin
        r_half[w_cur] <= ~r_half[w_cur];
        if (ch_ready[w_cur]) begin
          r_rd_half <= r_half[w_cur];
        end
      end
      if (r_state == ST_PREFETCH) begin
        r_beat <= '0;
      end else if (r_state == ST_DATA && wr_data_ready) begin
        r_beat <= w_beat_nxt;
      end
      if (r_state == ST_DONE) begin
        r_offset[w_cur] <= w_offset_wrap ? '0 : r_offset[w_cur] + OFS_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_advance     = 1'b0;
    ch_rd_valid   = '0;
    ch_rd_addr    = '0;
    wr_cmd_valid  = 1'b0;
    wr_cmd_addr   = '0;
    wr_cmd_id     = '0;
    wr_data       = '0;
    wr_data_valid = 1'b0;
    wr_data_last  = 1'b0;
    frame_done    = '0;
    case (r_state)
      ST_IDLE: begin
        w_load      = 1'b1;
        w_state_nxt = ST_PROBE;
      end
      ST_PROBE: begin
        ch_rd_valid[w_cur] = 1'b1;
        if (r_probe_cnt) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ch_ready[w_cur]) begin
          w_state_nxt = ST_CMD;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = w_cmd_addr;
        wr_cmd_id    = CH_ID_W'(w_cur);
        if (wr_cmd_ready) begin
          w_state_nxt = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        ch_rd_addr  = {r_rd_half, {BEAT_IDX_W{1'b0}}};
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        // RAM has one cycle of latency, so present the address of the beat shown next cycle.
        wr_data       = w_ch_data[w_cur];
        wr_data_valid = 1'b1;
        wr_data_last  = w_last_beat;
        ch_rd_addr    = {r_rd_half, w_beat_sel};
        if (wr_data_ready && w_last_beat) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done[w_cur] = w_offset_wrap;
        w_advance         = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_video_wr_arbiter.sv
// tb/tb_video_wr_arbiter.sv - self-checking bench for video_wr_arbiter with RAM model and beat scoreboard
module tb_video_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [3:0]     ch_rd_valid;
  logic [3:0]     ch_ready;
  logic [4:0]     ch_rd_addr;
  logic [1023:0]  ch_rd_data;
  logic           wr_cmd_valid;
  logic           wr_cmd_ready;
  logic [27:0]    wr_cmd_addr;
  logic [3:0]     wr_cmd_id;
  logic [255:0]   wr_data;
  logic           wr_data_valid;
  logic           wr_data_ready;
  logic           wr_data_last;
  logic [3:0]     frame_done;

  int total = 0;
  int bad   = 0;

  video_wr_arbiter #(
    .FRAME_BEATS    (32),
    .CH_BASE_STRIDE (28'h0100000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_rd_valid   (ch_rd_valid),
    .ch_ready      (ch_ready),
    .ch_rd_addr    (ch_rd_addr),
    .ch_rd_data    (ch_rd_data),
    .wr_cmd_valid  (wr_cmd_valid),
    .wr_cmd_ready  (wr_cmd_ready),
    .wr_cmd_addr   (wr_cmd_addr),
    .wr_cmd_id     (wr_cmd_id),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data_last  (wr_data_last),
    .frame_done    (frame_done)
  );

  function automatic logic [255:0] ram_word(input int ch, input logic [4:0] a);
    logic [7:0] b;
    b = {ch[2:0], a};
    return {32{b}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Sampler RAMs: registered output, one cycle of read latency.
  logic [255:0] ram_q [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ram_q[i] <= ram_word(i, ch_rd_addr);
    end
  end

  always_comb begin
    ch_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      ch_rd_data[i*256 +: 256] = ram_q[i];
    end
  end

  // Scoreboard: probe-count half model, beats pushed on command accept, popped on beat accept.
  logic [255:0] exp_q [$];
  int           probe_cnt [4];
  logic         half_at_probe [4];
  logic [3:0]   prev_valid;
  int           fd_pulses = 0;

  initial begin
    logic [255:0] e;
    int id;
    prev_valid = '0;
    for (int i = 0; i < 4; i++) begin
      probe_cnt[i]     = 0;
      half_at_probe[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        exp_q.delete();
        prev_valid = '0;
        for (int i = 0; i < 4; i++) begin
          probe_cnt[i]     = 0;
          half_at_probe[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (ch_rd_valid[i] && !prev_valid[i]) begin
            half_at_probe[i] = probe_cnt[i][0];
            probe_cnt[i]++;
          end
        end
        prev_valid = ch_rd_valid;
        fd_pulses += $countones(frame_done);
        if (wr_cmd_valid && wr_cmd_ready) begin
          id = int'(wr_cmd_id);
          for (int b = 0; b < 16; b++) begin
            exp_q.push_back(ram_word(id, {half_at_probe[id], 4'(b)}));
          end
        end
        if (wr_data_valid && wr_data_ready) begin
          chk("sb_beat_expected", 256'(exp_q.size() != 0), 256'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_data", wr_data, e);
            chk("sb_last", 256'(wr_data_last), 256'(exp_q.size() == 0));
          end
        end
      end
    end
  end

  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (wr_cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_burst(input bit toggle, output int dcyc, output bit got_last);
    dcyc     = 0;
    got_last = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wr_data_valid) begin
        wr_data_ready = toggle ? (dcyc % 2 == 0) : 1'b1;
        dcyc++;
      end
      #1;
      if (wr_data_valid && wr_data_ready && wr_data_last) begin
        got_last = 1'b1;
        break;
      end
    end
    wr_data_ready = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  exp_id;
    logic [27:0] exp_addr;
    bit          toggle;
    bit          stall;
    logic [3:0]  exp_fd;
  } row_t;

  row_t rows [7];

  initial begin
    bit         seen;
    bit         got_last;
    bit         stable;
    bit         hit;
    int         dcyc;
    int         acc;
    logic [3:0] exp;
    logic [27:0] sa;
    logic [3:0]  si;

    rows[0] = '{4'b0100, 4'd2, 28'h0200000, 1'b0, 1'b0, 4'b0000};
    rows[1] = '{4'b0100, 4'd2, 28'h0200010, 1'b1, 1'b0, 4'b0100};
    rows[2] = '{4'b0001, 4'd0, 28'h0000000, 1'b0, 1'b0, 4'b0000};
    rows[3] = '{4'b0001, 4'd0, 28'h0000010, 1'b0, 1'b0, 4'b0001};
    rows[4] = '{4'b0001, 4'd0, 28'h0000000, 1'b0, 1'b0, 4'b0000};
    rows[5] = '{4'b1000, 4'd3, 28'h0300000, 1'b0, 1'b1, 4'b0000};
    rows[6] = '{4'b0010, 4'd1, 28'h0100000, 1'b1, 1'b0, 4'b0000};

    rst           = 1'b0;
    ch_ready      = '0;
    wr_cmd_ready  = 1'b1;
    wr_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_valid",   256'(ch_rd_valid),   256'(0));
    chk("rst_rd_addr",    256'(ch_rd_addr),    256'(0));
    chk("rst_cmd_valid",  256'(wr_cmd_valid),  256'(0));
    chk("rst_cmd_addr",   256'(wr_cmd_addr),   256'(0));
    chk("rst_data_valid", 256'(wr_data_valid), 256'(0));
    chk("rst_frame_done", 256'(frame_done),    256'(0));

    // Nobody ready: 2-cycle probe strobes rotating 0,1,2,3,0 with a 4-cycle period.
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      exp = ((k % 4 == 1) || (k % 4 == 2)) ? (4'b0001 << ((k / 4) % 4)) : 4'b0000;
      chk("idle_probe", 256'({wr_cmd_valid, ch_rd_valid}), 256'({1'b0, exp}));
    end

    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      wr_cmd_ready = !rows[r].stall;
      ch_ready     = rows[r].mask;
      wait_cmd(seen);
      chk("cmd_seen", 256'(wr_cmd_valid), 256'(1));
      ch_ready = '0;
      if (rows[r].stall) begin
        sa     = wr_cmd_addr;
        si     = wr_cmd_id;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #1;
          if (wr_cmd_addr !== sa || wr_cmd_id !== si || ch_rd_valid != 4'b0 || !wr_cmd_valid) begin
            stable = 1'b0;
          end
        end
        chk("cmd_stall_stable", 256'(stable), 256'(1));
        @(negedge clk);
        wr_cmd_ready = 1'b1;
        #1;
      end
      chk("cmd_id",   256'(wr_cmd_id),   256'(rows[r].exp_id));
      chk("cmd_addr", 256'(wr_cmd_addr), 256'(rows[r].exp_addr));
      run_burst(rows[r].toggle, dcyc, got_last);
      chk("burst_last_seen", 256'(got_last), 256'(1));
      chk("data_cycles", 256'(dcyc), rows[r].toggle ? 256'(31) : 256'(16));
      @(negedge clk);
      #1;
      chk("frame_done", 256'(frame_done), 256'(rows[r].exp_fd));
    end

    // Reset dropped while beat 7 is on the bus.
    @(negedge clk);
    ch_ready = 4'b0010;
    wait_cmd(seen);
    chk("midrst_cmd_seen", 256'(wr_cmd_valid), 256'(1));
    ch_ready = '0;
    acc = 0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wr_data_valid && acc == 7) begin
        rst = 1'b0;
        hit = 1'b1;
        break;
      end
      #1;
      if (wr_data_valid && wr_data_ready) begin
        acc++;
      end
    end
    chk("midrst_at_beat7", 256'(hit), 256'(1));
    @(negedge clk);
    #1;
    chk("midrst_outputs", 256'({ch_rd_valid, ch_rd_addr, wr_cmd_valid, wr_cmd_addr, wr_cmd_id,
                               wr_data_valid, wr_data_last, frame_done}), 256'(0));
    chk("midrst_wr_data", wr_data, 256'(0));
    ch_ready = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1;
    chk("restart_probe_ch0", 256'(ch_rd_valid), 256'(4'b0001));
    wait_cmd(seen);
    chk("restart_cmd_seen", 256'(wr_cmd_valid), 256'(1));
    ch_ready = '0;
    chk("restart_cmd_id",   256'(wr_cmd_id),   256'(0));
    chk("restart_cmd_addr", 256'(wr_cmd_addr), 256'(0));
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (wr_data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("restart_first_beat_half0", wr_data, ram_word(0, 5'd0));
    run_burst(1'b0, dcyc, got_last);
    chk("restart_burst_last_seen", 256'(got_last), 256'(1));
    repeat (4) @(negedge clk);
    #1;

    chk("fd_pulses",  256'(fd_pulses),    256'(2));
    chk("sb_drained", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_wr_arbiter.md
# video_wr_arbiter

Round-robin scheduler that shares one DDR write-burst port between CH_NUM video sampling channels. It polls each channel's half-buffer ready status and reads one 16-beat burst from the granted channel's sampling RAM. It streams that burst to the DDR write interface at a per-channel frame address. It sits in the read-clock domain, between the channel samplers and the DDR write controller.

## Interface
- CH_NUM, 4: number of sampling channels.
- DQ_WIDTH, 32: DDR DQ width; one beat is DQ_WIDTH*8 bits.
- RD_ADDR_LEN, 5: sampler RAM read address width; MSB selects the half-buffer.
- BURST_LEN, 16: beats per burst; equals 2^(RD_ADDR_LEN-1).
- CTRL_ADDR_WIDTH, 28: DDR address width.
- FRAME_BEATS, 3600: beats per channel frame (320x180 RGB565 / 256 bits).
- CH_BASE_STRIDE, 28'h0100000: DDR address distance between channel frame regions.

- clk  in  1  single clock (same clock as sampler rd_clk).
- rst  in  1  synchronous, active-low reset.
- ch_rd_valid  out  CH_NUM  per-channel probe strobe (sampler rd_valid).
- ch_ready  in  CH_NUM  per-channel burst-ready (sampler data_out_ready).
- ch_rd_addr  out  RD_ADDR_LEN  shared RAM read address, routed to all channels.
- ch_rd_data  in  CH_NUM*DQ_WIDTH*8  flattened RAM read data; channel i occupies slice i.
- wr_cmd_valid  out  1  burst command valid.
- wr_cmd_ready  in  1  command accepted.
- wr_cmd_addr  out  CTRL_ADDR_WIDTH  burst start address, in beats.
- wr_cmd_id  out  4  granted channel index.
- wr_data  out  DQ_WIDTH*8  beat data.
- wr_data_valid  out  1  beat valid.
- wr_data_ready  in  1  beat accepted.
- wr_data_last  out  1  last beat of burst.
- frame_done  out  CH_NUM  one-cycle pulse when a channel's final frame beat is accepted.

## Operation
- FSM states: IDLE, PROBE, CHECK, CMD, PREFETCH, DATA, DONE.
- IDLE: load the channel pointer `cur` from `next`, then go to PROBE.
- PROBE: drive ch_rd_valid[cur]=1 for exactly 2 cycles, then go to CHECK.
- CHECK (1 cycle, ch_rd_valid low):
  - Sample ch_ready[cur] and toggle half[cur].
  - If ch_ready[cur] was 1: latch rd_half = old half[cur] and go to CMD.
  - Otherwise: set next = cur+1 mod CH_NUM and go to IDLE.
- half[cur] toggles on every probe, successful or not, to stay in lockstep with the sampler's probe counter. A channel's first probe after reset reads half 0.
- CMD:
  - wr_cmd_valid=1.
  - wr_cmd_addr = cur*CH_BASE_STRIDE + offset[cur]*BURST_LEN.
  - wr_cmd_id = cur.
  - Hold all three until wr_cmd_ready, then go to PREFETCH.
- PREFETCH (1 cycle): ch_rd_addr = {rd_half, 0}; beat = 0; go to DATA.
- DATA:
  - wr_data = ch_rd_data slice cur; wr_data_valid=1; wr_data_last = (beat==BURST_LEN-1).
  - ch_rd_addr = {rd_half, beat+1} when wr_data_ready is high, else {rd_half, beat}.
  - beat increments on each accepted beat.
  - On the accepted last beat, go to DONE.
- DONE (1 cycle):
  - offset[cur] += 1. Wrap to 0 when it reaches FRAME_BEATS/BURST_LEN, and pulse frame_done[cur] at that point.
  - Set next = cur+1 mod CH_NUM and go to IDLE.
- Arbitration is strict round-robin over probe slots. A granted channel cannot be probed again until every other channel has been probed once.

## Timing
- Reset values:
  - All outputs are 0; ch_rd_addr = 0.
  - FSM is in IDLE; cur = next = 0.
  - All half bits and offsets are 0.
- Sampler RAM read latency is 1 cycle, with registered output: data for address A is valid on the cycle after A is presented.
- wr_data is stable while wr_data_valid=1 and wr_data_ready=0, because the address is held.
- Minimum failed probe is 4 cycles (IDLE, PROBE×2, CHECK).
- Minimum successful burst with no backpressure is 4+1+1+16+1 = 23 cycles.
- Backpressure on wr_cmd_ready or wr_data_ready only stretches CMD or DATA; nothing else changes.
- wr_data_valid never deasserts mid-burst. wr_data_last is high on exactly one beat per burst.
- Offset wrap: the burst in which offset reaches FRAME_BEATS/BURST_LEN-1 writes the last slot; the next burst for that channel writes offset 0.
- If rst goes low mid-burst, all outputs drop on the next clk edge; the partial burst is abandoned with no completion.

## Structure
- Shared package video_pkg:
  - FSM state encoding.
  - CH_NUM, BURST_LEN, and the beat-width localparam (DQ_WIDTH*8).
  - Channel ID width.
- One sub-module, rr_pointer: holds cur/next and advances modulo CH_NUM. Everything else is flat in video_wr_arbiter.

## Test plan
- All ch_ready=0, no backpressure:
  - ch_rd_valid pulses 2 cycles each in order 0,1,2,3,0 with a 4-cycle period per channel.
  - No wr_cmd_valid is ever issued.
- ch_ready[2]=1 only:
  - One command with wr_cmd_addr = 2*0x100000 and wr_cmd_id = 2.
  - 16 beats equal to RAM half-0 words 0..15, with last on beat 15.
  - The next probe of channel 2 reads half 1.
- wr_data_ready toggled 1/0 every cycle during DATA:
  - Beats arrive in order with none duplicated or dropped.
  - Burst completes in 31 DATA cycles.
- Channel 0 always ready, FRAME_BEATS=32:
  - Offsets go 0,1,0.
  - frame_done[0] pulses once, after the second burst.
- Hold wr_cmd_ready=0 for 10 cycles: wr_cmd_addr and wr_cmd_id stay stable and no ch_rd_valid is asserted.
- rst low at beat 7:
  - Next cycle all outputs are 0.
  - After release, probing restarts at channel 0, half 0.
